uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a single-entry output register.
//   Samples each bit at its centre, using a cycle counter timed from the
//   synchronised falling edge of the start bit.
// Ports:
//   sys_clk   - system clock, all state changes on the rising edge
//   reset     - asynchronous, active-high reset
//   UART_RX   - serial input, idle high, LSB first, asynchronous to sys_clk
//   rx_data   - last correctly framed byte
//   rx_valid  - rx_data holds a byte not yet acknowledged
//   rx_ack    - consumer takes rx_data (ignored while rx_valid=0)
//   overrun   - sticky: a byte was overwritten before being acknowledged
//   frame_err - one-cycle pulse when a stop bit is sampled low
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun,
  output logic       frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_sync;
  logic          w_rxs;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_byte_done;
  logic          w_stop_err;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_overrun;
  logic          r_frame_err;

  assign w_rxs     = r_sync[1];
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[0], UART_RX};
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_byte_done = 1'b0;
    w_stop_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (!w_rxs) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          // A start bit that is high again at its centre was a glitch.
          w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt   = '0;
          // Shift in at the MSB so the first (LSB) sample ends in bit 0.
          w_shift_nxt = {w_rxs, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_nxt = '0;
          if (w_rxs) begin
            w_byte_done = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_err  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line returns high so a break is not re-received.
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_err;
      if (w_byte_done) begin
        // A new byte always loads; overrun only when the old one was
        // still pending and not taken on this same edge.
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !rx_ack) r_overrun <= 1'b1;
      end else if (rx_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
        r_overrun  <= 1'b0;
      end
    end
  end

endmodule
